// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared widths, FSM encoding and special-case classification for fp_mul_seq
package fp_pkg;

  localparam int N_EXP  = 11;
  localparam int N_MAN  = 52;
  localparam int EXP_W  = N_EXP + 2;
  localparam int OEXP_W = N_EXP + 3;
  localparam int PROD_W = 2 * N_MAN + 2;
  localparam int CNT_W  = $clog2(N_MAN + 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } cls_t;

  // nan beats inf beats zero; inf*zero is the only case that creates a nan
  function automatic cls_t special_class(input logic a_nan, input logic a_inf, input logic a_zero,
                                         input logic b_nan, input logic b_inf, input logic b_zero);
    cls_t c;
    c.nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    c.inf  = !c.nan && (a_inf | b_inf);
    c.zero = !c.nan && !c.inf && (a_zero | b_zero);
    return c;
  endfunction

endpackage

// File: rtl/fp_mul_iter.sv
// rtl/fp_mul_iter.sv - radix-2 shift-add mantissa multiplier, one partial product per cycle
module fp_mul_iter
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_MAN:0]    multiplicand,
  input  logic [N_MAN:0]    multiplier,
  output logic              busy,
  output logic [PROD_W-1:0] product
);

  logic [N_MAN:0]   mcand_q, mcand_d;
  logic [N_MAN:0]   hi_q, hi_d;
  logic [N_MAN:0]   lo_q, lo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_MAN+1:0] sum;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    if (start) begin
      mcand_d = multiplicand;
      hi_d    = '0;
      lo_d    = multiplier;
      cnt_d   = CNT_W'(N_MAN + 1);
    end else if (cnt_q != '0) begin
      // low product bits retire into the multiplier register as it empties
      hi_d  = sum[N_MAN+1:1];
      lo_d  = {sum[0], lo_q[N_MAN:1]};
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Drops during the final step so the owner can leave MUL on the edge the product completes
  assign busy    = (cnt_q > CNT_W'(1));
  assign product = {hi_q, lo_q};

endmodule

// File: rtl/fp_mul_seq.sv
// rtl/fp_mul_seq.sv - sequential fp multiplier core: FSM, special cases, exponent add, normalization
module fp_mul_seq
  import fp_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     a_sign,
  input  logic                     b_sign,
  input  logic signed [EXP_W-1:0]  a_exp,
  input  logic signed [EXP_W-1:0]  b_exp,
  input  logic [N_MAN:0]           a_man,
  input  logic [N_MAN:0]           b_man,
  input  logic                     a_nan,
  input  logic                     a_inf,
  input  logic                     a_zero,
  input  logic                     b_nan,
  input  logic                     b_inf,
  input  logic                     b_zero,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sign,
  output logic signed [OEXP_W-1:0] out_exp,
  output logic [PROD_W-1:0]        out_man,
  output logic                     out_nan,
  output logic                     out_inf,
  output logic                     out_zero
);

  localparam logic signed [OEXP_W-1:0] EXP_ONE = OEXP_W'(1);

  state_e                    state_q, state_d;
  logic                      sign_q, sign_d;
  logic signed [OEXP_W-1:0]  exp_q, exp_d;
  cls_t                      cls_q, cls_d;
  cls_t                      cls_in;
  logic                      accept;
  logic                      iter_start;
  logic                      iter_busy;
  logic [PROD_W-1:0]         prod;

  assign cls_in     = special_class(a_nan, a_inf, a_zero, b_nan, b_inf, b_zero);
  assign accept     = (state_q == ST_IDLE) && in_valid;
  assign iter_start = accept && (cls_in == '0);

  fp_mul_iter u_iter (
    .clk          (clk),
    .rst          (rst),
    .start        (iter_start),
    .multiplicand (a_man),
    .multiplier   (b_man),
    .busy         (iter_busy),
    .product      (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = (cls_in != '0) ? ST_DONE : ST_MUL;
      ST_MUL:  if (!iter_busy) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sign_d = sign_q;
    exp_d  = exp_q;
    cls_d  = cls_q;
    if (accept) begin
      sign_d = cls_in.nan ? 1'b0 : (a_sign ^ b_sign);
      exp_d  = $signed({a_exp[EXP_W-1], a_exp}) + $signed({b_exp[EXP_W-1], b_exp});
      cls_d  = cls_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      cls_q  <= '0;
    end else begin
      sign_q <= sign_d;
      exp_q  <= exp_d;
      cls_q  <= cls_d;
    end
  end

  // Iterator registers stay frozen once the count is spent, so DONE outputs are stable
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    out_sign  = sign_q;
    out_nan   = cls_q.nan;
    out_inf   = cls_q.inf;
    out_zero  = cls_q.zero;
    out_man   = '0;
    out_exp   = '0;
    if (cls_q == '0) begin
      if (prod[PROD_W-1]) begin
        out_man = prod;
        out_exp = exp_q + EXP_ONE;
      end else begin
        out_man = prod << 1;
        out_exp = exp_q;
      end
    end
  end

endmodule
